// File: rtl/busy_arb_pkg.sv
// rtl/busy_arb_pkg.sv - state/error encodings and index helper for busy_gnt_arbiter
package busy_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_GNT
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_EARLY_GNT,
    ERR_EXTRA_BUSY,
    ERR_TIMEOUT
  } err_e;

  function automatic int wrap_inc(input int value, input int modulus);
    return (value + 1 >= modulus) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set req bit at or after ptr
module rr_pick
  import busy_arb_pkg::*;
#(
  parameter int NUM_CLI = 4,
  localparam int IDX_W = $clog2(NUM_CLI)
) (
  input  logic [NUM_CLI-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin : scan
    int c;
    valid = 1'b0;
    idx   = '0;
    c     = int'(ptr);
    for (int i = 0; i < NUM_CLI; i++) begin
      if (!valid && req[IDX_W'(c)]) begin
        valid = 1'b1;
        idx   = IDX_W'(c);
      end
      c = wrap_inc(c, NUM_CLI);
    end
  end

endmodule

// File: rtl/busy_gnt_arbiter.sv
// rtl/busy_gnt_arbiter.sv - round-robin owner of a shared req/busy/gnt resource,
// forwarding the grant after BUSY_COUNT busy strobes and flagging protocol errors
module busy_gnt_arbiter
  import busy_arb_pkg::*;
#(
  parameter int NUM_CLI    = 4,
  parameter int BUSY_COUNT = 3,
  parameter int TIMEOUT    = 64,
  localparam int IDX_W = $clog2(NUM_CLI)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CLI-1:0] cli_req,
  output logic [NUM_CLI-1:0] cli_gnt,
  output logic [NUM_CLI-1:0] cli_err,
  output logic               res_req,
  input  logic               res_busy,
  input  logic               res_gnt,
  output logic [IDX_W-1:0]   owner,
  output logic               active,
  output logic [1:0]         err_code
);

  localparam int BCW = $clog2(BUSY_COUNT + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [BCW-1:0] BUSY_LAST = BCW'(BUSY_COUNT - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [BCW-1:0]     busy_cnt_q, busy_cnt_d;
  logic [TCW-1:0]     tmo_cnt_q, tmo_cnt_d;

  logic [NUM_CLI-1:0] gnt_d, err_d;
  logic               res_req_d, active_d;
  logic [IDX_W-1:0]   owner_d;
  logic [1:0]         err_code_d;
  err_e               fail;
  logic               finish;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  rr_pick #(.NUM_CLI(NUM_CLI)) u_pick (
    .req   (cli_req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      busy_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      cli_gnt    <= '0;
      cli_err    <= '0;
      res_req    <= 1'b0;
      owner      <= '0;
      active     <= 1'b0;
      err_code   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      busy_cnt_q <= busy_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      cli_gnt    <= gnt_d;
      cli_err    <= err_d;
      res_req    <= res_req_d;
      owner      <= owner_d;
      active     <= active_d;
      err_code   <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    busy_cnt_d = busy_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    gnt_d      = '0;
    err_d      = '0;
    res_req_d  = 1'b0;
    owner_d    = owner;
    active_d   = active;
    err_code_d = err_code;
    fail       = ERR_NONE;
    finish     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d   = ISSUE;
          owner_d   = pick_idx;
          active_d  = 1'b1;
          res_req_d = 1'b1;
        end
      end
      ISSUE: begin
        state_d    = WAIT_BUSY;
        busy_cnt_d = '0;
        tmo_cnt_d  = '0;
      end
      WAIT_BUSY: begin
        tmo_cnt_d = tmo_cnt_q + TCW'(1);
        // A grant arriving with the final busy strobe is still early.
        if (res_gnt) begin
          fail = ERR_EARLY_GNT;
        end else if (tmo_cnt_q == TMO_LAST) begin
          fail = ERR_TIMEOUT;
        end else if (res_busy) begin
          busy_cnt_d = busy_cnt_q + BCW'(1);
          if (busy_cnt_q == BUSY_LAST) begin
            state_d = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        tmo_cnt_d = tmo_cnt_q + TCW'(1);
        if (res_gnt) begin
          gnt_d[owner] = 1'b1;
          finish       = 1'b1;
        end else if (tmo_cnt_q == TMO_LAST) begin
          fail = ERR_TIMEOUT;
        end else if (res_busy) begin
          fail = ERR_EXTRA_BUSY;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fail != ERR_NONE) begin
      err_d[owner] = 1'b1;
      err_code_d   = fail;
      finish       = 1'b1;
    end

    // Success and abort both hand the pointer to the client after the owner.
    if (finish) begin
      state_d  = IDLE;
      active_d = 1'b0;
      ptr_d    = IDX_W'(wrap_inc(int'(owner), NUM_CLI));
    end
  end

  logic [BCW-1:0] busy_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_seen <= '0;
    end else if (res_req) begin
      busy_seen <= '0;
    end else if (active && res_busy && busy_seen != BCW'(BUSY_COUNT)) begin
      busy_seen <= busy_seen + BCW'(1);
    end
  end

  a_pulse_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({cli_gnt, cli_err}));

  a_req_single: assert property (@(posedge clk) disable iff (!rst_n)
    res_req |=> !res_req);

  a_gnt_after_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (|cli_gnt) |-> (busy_seen == BCW'(BUSY_COUNT)));

endmodule

// File: tb/tb_busy_gnt_arbiter.sv
// tb/tb_busy_gnt_arbiter.sv - directed and randomized checks of busy_gnt_arbiter
// against a transaction-level outcome model
module tb_busy_gnt_arbiter;

  localparam int N   = 4;
  localparam int BC  = 3;
  localparam int TMO = 64;
  localparam int BIG = 1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cli_req;
  logic [3:0] cli_gnt;
  logic [3:0] cli_err;
  logic       res_req;
  logic       res_busy;
  logic       res_gnt;
  logic [1:0] owner;
  logic       active;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  busy_gnt_arbiter #(.NUM_CLI(N), .BUSY_COUNT(BC), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cli_req  (cli_req),
    .cli_gnt  (cli_gnt),
    .cli_err  (cli_err),
    .res_req  (res_req),
    .res_busy (res_busy),
    .res_gnt  (res_gnt),
    .owner    (owner),
    .active   (active),
    .err_code (err_code)
  );

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;
  int m_err  = 0;
  bit noise  = 1'b0;
  bit s_busy [0:127];
  bit s_gnt  [0:127];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_pick(input logic [3:0] r);
    for (int i = 0; i < N; i++) begin
      int c;
      c = (m_ptr + i) % N;
      if (r[2'(c)]) return c;
    end
    return -1;
  endfunction

  // Outcome from event positions: g first grant, p the BC-th busy, x the one after.
  task automatic predict(output int kind, output int at);
    int g, p, x, nb;
    g = BIG; p = BIG; x = BIG; nb = 0;
    for (int j = 0; j < 128; j++) begin
      if (s_gnt[j] && g == BIG) g = j;
      if (s_busy[j]) begin
        nb++;
        if (nb == BC) p = j;
        if (nb == BC + 1) x = j;
      end
    end
    if (g <= p && g <= TMO - 1) begin
      kind = 1; at = g;
    end else if (p >= TMO - 1) begin
      kind = 3; at = TMO - 1;
    end else if (g <= x && g <= TMO - 1) begin
      kind = 0; at = g;
    end else if (x < TMO - 1) begin
      kind = 2; at = x;
    end else begin
      kind = 3; at = TMO - 1;
    end
  endtask

  task automatic clear_script();
    for (int j = 0; j < 128; j++) begin
      s_busy[j] = 1'b0;
      s_gnt[j]  = 1'b0;
    end
  endtask

  task automatic rand_script();
    int pos, nbusy;
    clear_script();
    if ($urandom_range(0, 11) == 0) return;
    nbusy = int'($urandom_range(BC - 1, BC + 1));
    pos   = int'($urandom_range(0, 2));
    for (int b = 0; b < nbusy; b++) begin
      s_busy[pos] = 1'b1;
      pos += 1 + (($urandom_range(0, 15) == 0) ? int'($urandom_range(10, 25))
                                                 : int'($urandom_range(0, 2)));
    end
    if ($urandom_range(0, 7) != 0) s_gnt[int'($urandom_range(0, pos + 2))] = 1'b1;
  endtask

  task automatic do_txn(input bit rereq, input bit drop_owner, input bit junk_issue);
    int exp_owner, kind, at, drop_at;
    logic [3:0] oh;
    exp_owner = model_pick(cli_req);
    predict(kind, at);
    drop_at  = drop_owner ? int'($urandom_range(0, at)) : -1;
    res_busy = 1'b0;
    res_gnt  = 1'b0;
    @(posedge clk); #1;
    check("issue_res_req", {31'd0, res_req}, 32'd1);
    check("issue_owner", {30'd0, owner}, exp_owner);
    check("issue_active", {31'd0, active}, 32'd1);
    if (junk_issue) begin
      res_busy = 1'($urandom_range(0, 1));
      res_gnt  = 1'($urandom_range(0, 1));
    end
    for (int j = 0; j <= at; j++) begin
      @(posedge clk); #1;
      check("in_flight", {22'd0, active, cli_gnt, cli_err, res_req}, {22'd0, 1'b1, 9'd0});
      res_busy = s_busy[j];
      res_gnt  = s_gnt[j];
      if (j == drop_at) cli_req[2'(exp_owner)] = 1'b0;
      if (noise && $urandom_range(0, 3) == 0) cli_req[2'($urandom_range(0, 3))] = 1'b1;
    end
    @(posedge clk); #1;
    oh = 4'd1 << exp_owner;
    if (kind == 0) begin
      check("gnt_vec", {28'd0, cli_gnt}, {28'd0, oh});
      check("gnt_err_vec", {28'd0, cli_err}, 32'd0);
    end else begin
      m_err = kind;
      check("err_vec", {28'd0, cli_err}, {28'd0, oh});
      check("err_gnt_vec", {28'd0, cli_gnt}, 32'd0);
    end
    check("err_code", {30'd0, err_code}, m_err);
    check("done_active", {31'd0, active}, 32'd0);
    m_ptr    = (exp_owner + 1) % N;
    res_busy = 1'b0;
    res_gnt  = 1'b0;
    cli_req[2'(exp_owner)] = rereq;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    cli_req  = '0;
    res_busy = 1'b0;
    res_gnt  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    m_err = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    cli_req  = '0;
    res_busy = 1'b0;
    res_gnt  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {20'd0, cli_gnt, cli_err, res_req, owner, active, err_code}, 32'd0);
    apply_reset();

    // Spaced busy strobes, grant one cycle after the last
    cli_req = 4'b0001;
    clear_script();
    s_busy[1] = 1'b1; s_busy[3] = 1'b1; s_busy[5] = 1'b1; s_gnt[6] = 1'b1;
    do_txn(1'b0, 1'b0, 1'b0);

    // All clients holding requests: rotation 0,1,2,3,0
    apply_reset();
    cli_req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      clear_script();
      s_busy[0] = 1'b1; s_busy[1] = 1'b1; s_busy[2] = 1'b1; s_gnt[3] = 1'b1;
      do_txn(1'b1, 1'b0, 1'b0);
    end

    // Grant after only two busy strobes, then the next client is served
    clear_script();
    s_busy[0] = 1'b1; s_busy[1] = 1'b1; s_gnt[2] = 1'b1;
    do_txn(1'b1, 1'b0, 1'b0);
    clear_script();
    s_busy[0] = 1'b1; s_busy[2] = 1'b1; s_busy[4] = 1'b1; s_gnt[5] = 1'b1;
    do_txn(1'b1, 1'b0, 1'b0);

    // Extra busy in the grant wait, then a silent resource
    clear_script();
    s_busy[0] = 1'b1; s_busy[1] = 1'b1; s_busy[2] = 1'b1; s_busy[3] = 1'b1;
    do_txn(1'b1, 1'b0, 1'b0);
    clear_script();
    do_txn(1'b1, 1'b0, 1'b0);

    // Busy and grant together after the count; owner drops its request mid-op
    cli_req = 4'b0010;
    clear_script();
    s_busy[0] = 1'b1; s_busy[1] = 1'b1; s_busy[2] = 1'b1;
    s_busy[4] = 1'b1; s_gnt[4] = 1'b1;
    do_txn(1'b0, 1'b1, 1'b0);

    // Reset while waiting for busy: pointer returns to 0
    cli_req = 4'b0100;
    clear_script();
    s_busy[0] = 1'b1; s_busy[1] = 1'b1; s_busy[2] = 1'b1; s_gnt[3] = 1'b1;
    do_txn(1'b0, 1'b0, 1'b0);
    cli_req = 4'b1000;
    @(posedge clk); #1;
    check("t5_issue", {31'd0, res_req}, 32'd1);
    res_busy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    res_busy = 1'b0;
    check("t5_active", {31'd0, active}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_async_rst", {20'd0, cli_gnt, cli_err, res_req, owner, active, err_code}, 32'd0);
    cli_req = 4'b1100;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    m_err = 0;
    clear_script();
    s_busy[0] = 1'b1; s_busy[1] = 1'b1; s_busy[2] = 1'b1; s_gnt[3] = 1'b1;
    do_txn(1'b0, 1'b0, 1'b0);

    // Randomized traffic
    noise = 1'b1;
    for (int t = 0; t < 150; t++) begin
      if (cli_req == 4'b0000) begin
        @(posedge clk); #1;
        check("idle_quiet", {30'd0, res_req, active}, 32'd0);
        cli_req = 4'($urandom_range(1, 15));
      end
      rand_script();
      do_txn(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
